word_delay_line: RTL and testbench

WORD_DELAY_LINE -- requirements
Module: word_delay_line

---
 rtl/word_delay_pkg.sv | 40 ++++
 rtl/word_delay_line_if.sv | 40 ++++
 rtl/word_delay_tapmux.sv | 30 +++
 rtl/word_delay_line.sv | 120 ++++++++++++
 tb/tb_word_delay_line.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/word_delay_pkg.sv
// -----------------------------------------------------------------------------
// word_delay_pkg
// Shared constants and helpers for the word delay line:
//   DEFAULT_WIDTH / DEFAULT_DEPTH / DEFAULT_TAPW : default parameter values
//   clog2()      : ceiling log2, used at elaboration time only
//   fill_width() : width of the fill counter, able to hold 0..DEPTH
// -----------------------------------------------------------------------------
package word_delay_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_TAPW  = 6;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< result) < value) begin
                result = result + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // The fill counter counts 0..DEPTH inclusive, so it needs clog2(DEPTH+1) bits.
    function automatic int fill_width(input int depth);
        int w;
        w = clog2(depth + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage : word_delay_pkg

// File: rtl/word_delay_line_if.sv
// -----------------------------------------------------------------------------
// word_delay_line_if
// Bundles the data, control and status signals of the word delay line.
//   D_i, Enable_i, Rotate_i, Clear_i, TapSel_i : driven by the user (master)
//   Q_o, Tap_o, Fill_o, Valid_o, Changed_o     : driven by the delay line (slave)
// Clock and reset are plain ports on the delay line, not part of this bundle.
// -----------------------------------------------------------------------------
interface word_delay_line_if
    import word_delay_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int TAPW  = DEFAULT_TAPW
);

    localparam int FILLW = fill_width(DEPTH);

    logic [WIDTH-1:0] D_i;
    logic             Enable_i;
    logic             Rotate_i;
    logic             Clear_i;
    logic [TAPW-1:0]  TapSel_i;

    logic [WIDTH-1:0] Q_o;
    logic [WIDTH-1:0] Tap_o;
    logic [FILLW-1:0] Fill_o;
    logic             Valid_o;
    logic             Changed_o;

    modport master (
        output D_i, Enable_i, Rotate_i, Clear_i, TapSel_i,
        input  Q_o, Tap_o, Fill_o, Valid_o, Changed_o
    );

    modport slave (
        input  D_i, Enable_i, Rotate_i, Clear_i, TapSel_i,
        output Q_o, Tap_o, Fill_o, Valid_o, Changed_o
    );

endinterface : word_delay_line_if

// File: rtl/word_delay_tapmux.sv
// -----------------------------------------------------------------------------
// word_delay_tapmux
// Selects one stage of the delay line for observation.
//   stages  : the DEPTH stage words (stage 0 first)
//   tap_sel : stage index
//   tap     : stages[tap_sel] when tap_sel < DEPTH, otherwise all zero
// Purely combinational.
// -----------------------------------------------------------------------------
module word_delay_tapmux
    import word_delay_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int TAPW  = DEFAULT_TAPW
) (
    input  logic [WIDTH-1:0] stages [DEPTH],
    input  logic [TAPW-1:0]  tap_sel,
    output logic [WIDTH-1:0] tap
);

    // One-hot AND-OR mux: at most one index matches, so out-of-range
    // selects fall through to zero without any explicit range compare.
    always_comb begin
        tap = {WIDTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            tap = tap | ((tap_sel == TAPW'(k)) ? stages[k] : {WIDTH{1'b0}});
        end
    end

endmodule : word_delay_tapmux

// File: rtl/word_delay_line.sv
// -----------------------------------------------------------------------------
// word_delay_line
// DEPTH-stage, WIDTH-bit word delay line with enable, recirculation,
// synchronous clear, a selectable tap and a fill counter.
//   Clk_i     : clock, all state changes on the rising edge
//   Reset_n_i : asynchronous active-low reset
//   bus       : word_delay_line_if.slave
//       D_i       word shifted into stage 0
//       Enable_i  advance the line by one stage
//       Rotate_i  recirculate stage DEPTH-1 into stage 0 (only with Enable_i)
//       Clear_i   synchronous clear, overrides everything else
//       TapSel_i  stage shown on Tap_o
//       Q_o       stage DEPTH-1 (registered)
//       Tap_o     stage[TapSel_i] or zero when out of range (combinational)
//       Fill_o    number of valid stages, saturates at DEPTH
//       Valid_o   Fill_o == DEPTH
//       Changed_o one-cycle registered pulse after Q_o changed value
// -----------------------------------------------------------------------------
module word_delay_line
    import word_delay_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int TAPW  = DEFAULT_TAPW
) (
    input  logic               Clk_i,
    input  logic               Reset_n_i,
    word_delay_line_if.slave   bus
);

    localparam int FILLW = fill_width(DEPTH);
    localparam logic [FILLW-1:0] FILL_FULL = FILLW'(DEPTH);

    // Reject illegal parameter combinations while elaborating.
    if (DEPTH < 1 || DEPTH > 64) begin : g_bad_depth
        $error("word_delay_line: DEPTH must be in 1..64");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("word_delay_line: WIDTH must be >= 1");
    end
    if (TAPW < 1 || TAPW > 30 || (1 << TAPW) < DEPTH) begin : g_bad_tapw
        $error("word_delay_line: TapSel_i too narrow to address every stage");
    end

    logic [WIDTH-1:0] stage_r      [DEPTH];
    logic [WIDTH-1:0] stage_next_s [DEPTH];
    logic [FILLW-1:0] fill_r;
    logic [FILLW-1:0] fill_next_s;
    logic             changed_r;
    logic             changed_next_s;

    // Next-state of the stage array, fill counter and change pulse.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stage_next_s[k] = stage_r[k];
        end
        fill_next_s    = fill_r;
        changed_next_s = 1'b0;

        if (bus.Clear_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_next_s[k] = {WIDTH{1'b0}};
            end
            fill_next_s    = {FILLW{1'b0}};
            changed_next_s = 1'b0;
        end else if (bus.Enable_i) begin
            for (int k = 1; k < DEPTH; k++) begin
                stage_next_s[k] = stage_r[k-1];
            end
            if (bus.Rotate_i) begin
                // With DEPTH=1 this re-loads stage 0 with itself, i.e. a hold.
                stage_next_s[0] = stage_r[DEPTH-1];
                fill_next_s     = fill_r;
            end else begin
                stage_next_s[0] = bus.D_i;
                if (fill_r != FILL_FULL) begin
                    fill_next_s = fill_r + FILLW'(1);
                end else begin
                    fill_next_s = fill_r;
                end
            end
            changed_next_s = (stage_next_s[DEPTH-1] != stage_r[DEPTH-1]);
        end else begin
            changed_next_s = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_r[k] <= {WIDTH{1'b0}};
            end
            fill_r    <= {FILLW{1'b0}};
            changed_r <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_r[k] <= stage_next_s[k];
            end
            fill_r    <= fill_next_s;
            changed_r <= changed_next_s;
        end
    end

    assign bus.Q_o       = stage_r[DEPTH-1];
    assign bus.Fill_o    = fill_r;
    assign bus.Valid_o   = (fill_r == FILL_FULL);
    assign bus.Changed_o = changed_r;

    word_delay_tapmux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .TAPW  (TAPW)
    ) u_tapmux (
        .stages  (stage_r),
        .tap_sel (bus.TapSel_i),
        .tap     (bus.Tap_o)
    );

endmodule : word_delay_line

// File: tb/tb_word_delay_line.sv
// -----------------------------------------------------------------------------
// tb_word_delay_line
// Directed self-checking bench for word_delay_line, WIDTH=16, DEPTH=4.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_word_delay_line;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int TAPW  = 6;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    word_delay_line_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAPW(TAPW)) bus_if ();

    word_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAPW(TAPW)) dut (
        .Clk_i     (clk),
        .Reset_n_i (rst_n),
        .bus       (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic rot, input logic clr, input logic [15:0] d);
        bus_if.Enable_i = en;
        bus_if.Rotate_i = rot;
        bus_if.Clear_i  = clr;
        bus_if.D_i      = d;
    endtask

    logic [15:0] shift_words [4];
    logic [15:0] rot_exp     [4];
    logic [15:0] tap_exp     [4];

    initial begin
        total = 0;
        bad   = 0;
        shift_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        rot_exp     = '{16'h0002, 16'h0003, 16'h0004, 16'h0001};
        tap_exp     = '{16'h4444, 16'h3333, 16'h2222, 16'h1111};
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        bus_if.TapSel_i = 6'd0;

        // Reset state.
        #3;
        check_val("rst_q",       32'(bus_if.Q_o),       32'h0);
        check_val("rst_fill",    32'(bus_if.Fill_o),    32'h0);
        check_val("rst_valid",   32'(bus_if.Valid_o),   32'h0);
        check_val("rst_changed", 32'(bus_if.Changed_o), 32'h0);
        #4 rst_n = 1'b1;
        step();

        // Latency and fill: 1111..4444 on consecutive enables.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, shift_words[i]);
            step();
            check_val("lat_fill",    32'(bus_if.Fill_o),    32'(i + 1));
            check_val("lat_q",       32'(bus_if.Q_o),       (i == 3) ? 32'h1111 : 32'h0);
            check_val("lat_valid",   32'(bus_if.Valid_o),   (i == 3) ? 32'h1 : 32'h0);
            check_val("lat_changed", 32'(bus_if.Changed_o), (i == 3) ? 32'h1 : 32'h0);
        end
        drive(1'b0, 1'b0, 1'b0, 16'h9999);
        step();
        check_val("hold_changed", 32'(bus_if.Changed_o), 32'h0);
        check_val("hold_q",       32'(bus_if.Q_o),       32'h1111);
        check_val("hold_fill",    32'(bus_if.Fill_o),    32'h4);

        // Tap reads every stage, out-of-range reads zero.
        for (int i = 0; i < 4; i++) begin
            bus_if.TapSel_i = 6'(i);
            #1;
            check_val("tap_stage", 32'(bus_if.Tap_o), 32'(tap_exp[i]));
        end
        bus_if.TapSel_i = 6'd5;
        #1;
        check_val("tap_oob", 32'(bus_if.Tap_o), 32'h0);
        bus_if.TapSel_i = 6'd0;

        // Saturating fill while loading 1,2,3,4.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 16'(i));
            step();
        end
        check_val("sat_fill", 32'(bus_if.Fill_o), 32'h4);
        check_val("sat_q",    32'(bus_if.Q_o),    32'h1);

        // Rotate: Q goes 2,3,4,1, D_i=FFFF ignored, fill unchanged.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 16'hFFFF);
            step();
            check_val("rot_q",       32'(bus_if.Q_o),       32'(rot_exp[i]));
            check_val("rot_fill",    32'(bus_if.Fill_o),    32'h4);
            check_val("rot_changed", 32'(bus_if.Changed_o), 32'h1);
        end
        check_val("rot_tap0", 32'(bus_if.Tap_o), 32'h4);

        // Rotate without enable holds.
        drive(1'b0, 1'b1, 1'b0, 16'hFFFF);
        step();
        check_val("rot_noen_q", 32'(bus_if.Q_o), 32'h1);

        // Clear wins over enable and rotate.
        drive(1'b1, 1'b1, 1'b1, 16'hFFFF);
        step();
        check_val("clr_q",       32'(bus_if.Q_o),       32'h0);
        check_val("clr_fill",    32'(bus_if.Fill_o),    32'h0);
        check_val("clr_valid",   32'(bus_if.Valid_o),   32'h0);
        check_val("clr_changed", 32'(bus_if.Changed_o), 32'h0);
        bus_if.TapSel_i = 6'd1;
        #1;
        check_val("clr_tap1", 32'(bus_if.Tap_o), 32'h0);
        bus_if.TapSel_i = 6'd0;

        // Gapped enables: 00AA needs four enabled edges, gaps do not count.
        drive(1'b1, 1'b0, 1'b0, 16'h00AA);
        step();
        for (int e = 1; e < 4; e++) begin
            for (int g = 0; g < 3; g++) begin
                drive(1'b0, 1'b0, 1'b0, 16'h00AA);
                step();
                check_val("gap_q",       32'(bus_if.Q_o),       32'h0);
                check_val("gap_changed", 32'(bus_if.Changed_o), 32'h0);
                check_val("gap_fill",    32'(bus_if.Fill_o),    32'(e));
            end
            drive(1'b1, 1'b0, 1'b0, 16'h0000);
            step();
            check_val("gap_arrive", 32'(bus_if.Q_o), (e == 3) ? 32'h00AA : 32'h0);
        end
        check_val("gap_changed_arr", 32'(bus_if.Changed_o), 32'h1);

        // Identical consecutive words: no pulse once Q settles on 5A5A.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h5A5A);
            step();
            if (i == 3) begin
                check_val("same_first", 32'(bus_if.Changed_o), 32'h1);
            end else if (i >= 4) begin
                check_val("same_q",       32'(bus_if.Q_o),       32'h5A5A);
                check_val("same_changed", 32'(bus_if.Changed_o), 32'h0);
            end
        end

        // Asynchronous reset between edges, then a fresh first shift.
        drive(1'b1, 1'b0, 1'b0, 16'h1234);
        step();
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_q",     32'(bus_if.Q_o),     32'h0);
        check_val("arst_fill",  32'(bus_if.Fill_o),  32'h0);
        check_val("arst_valid", 32'(bus_if.Valid_o), 32'h0);
        #2 rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 16'hBEEF);
        step();
        check_val("post_fill",    32'(bus_if.Fill_o),    32'h1);
        check_val("post_q",       32'(bus_if.Q_o),       32'h0);
        check_val("post_changed", 32'(bus_if.Changed_o), 32'h0);
        check_val("post_tap0",    32'(bus_if.Tap_o),     32'hBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_word_delay_line
